// File: rtl/il_paren_stack_if.sv
// Command bus between the instruction decode stage and the IL front end.
// The decoder is the master and drives one command per valid/ready handshake.
interface il_paren_stack_if #(
    parameter int OPC_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_type;
    logic [OPC_W-1:0] cmd_opcode;
    logic [7:0]       cmd_operand;

    modport master (
        output cmd_valid,
        output cmd_type,
        output cmd_opcode,
        output cmd_operand,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_type,
        input  cmd_opcode,
        input  cmd_operand,
        output cmd_ready
    );
endinterface

// File: rtl/il_paren_stack.sv
// IL execution front end: holds the accumulator and carry flag, issues
// opcode/operand pairs to the combinational ALU, and implements IL
// parenthesised nesting with a stack of {pending opcode, saved accumulator}.
module il_paren_stack #(
    parameter int               OPC_W   = 4,
    parameter int               DEPTH   = 8,
    parameter logic [OPC_W-1:0] ADD_OPC = 4'd8,
    parameter logic [OPC_W-1:0] SUB_OPC = 4'd9,
    localparam int              AW      = $clog2(DEPTH),
    localparam int              DW      = AW + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    il_paren_stack_if.slave      cmd,
    output logic [OPC_W-1:0]     alu_opcode,
    output logic [7:0]           alu_op1,
    output logic [7:0]           alu_op2,
    input  logic [7:0]           alu_result,
    input  logic                 alu_carry,
    output logic [7:0]           acc_out,
    output logic                 carry_out,
    output logic [DW-1:0]        depth,
    output logic                 overflow_err,
    output logic                 underflow_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CALC = 1'b1;

    localparam logic [2:0] T_EXEC  = 3'd0;
    localparam logic [2:0] T_LOAD  = 3'd1;
    localparam logic [2:0] T_PUSH  = 3'd2;
    localparam logic [2:0] T_POP   = 3'd3;
    localparam logic [2:0] T_CLEAR = 3'd4;

    logic [0:0]       state_q, state_d;
    logic [7:0]       acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [OPC_W-1:0] alu_opcode_q, alu_opcode_d;
    logic [7:0]       alu_op1_q, alu_op1_d;
    logic [7:0]       alu_op2_q, alu_op2_d;

    logic [OPC_W+7:0] stack_q [DEPTH];
    logic             push_en;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    pop_idx;
    logic [DW-1:0]    depth_dec;
    logic             is_idle;
    logic             accept;
    logic             full;
    logic             empty;
    logic [OPC_W-1:0] pop_opcode;
    logic [7:0]       pop_acc;

    // Handshake and stack addressing derived from the current state.
    always_comb begin
        is_idle    = (state_q == S_IDLE);
        accept     = cmd.cmd_valid && is_idle;
        full       = (depth_q == DW'(DEPTH));
        empty      = (depth_q == '0);
        depth_dec  = depth_q - DW'(1);
        push_idx   = depth_q[AW-1:0];
        pop_idx    = depth_dec[AW-1:0];
        pop_opcode = stack_q[pop_idx][OPC_W+7:8];
        pop_acc    = stack_q[pop_idx][7:0];
    end

    assign cmd.cmd_ready = is_idle;

    // Next-state logic: command decode in IDLE, result capture in CALC.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        carry_d      = carry_q;
        depth_d      = depth_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        alu_opcode_d = alu_opcode_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        push_en      = 1'b0;

        if (state_q == S_CALC) begin
            acc_d = alu_result;
            if ((alu_opcode_q == ADD_OPC) || (alu_opcode_q == SUB_OPC)) begin
                carry_d = alu_carry;
            end
            state_d = S_IDLE;
        end else if (accept) begin
            case (cmd.cmd_type)
                T_EXEC: begin
                    alu_opcode_d = cmd.cmd_opcode;
                    alu_op1_d    = acc_q;
                    alu_op2_d    = cmd.cmd_operand;
                    state_d      = S_CALC;
                end
                T_LOAD: begin
                    acc_d = cmd.cmd_operand;
                end
                T_PUSH: begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        depth_d = depth_q + DW'(1);
                        acc_d   = cmd.cmd_operand;
                    end
                end
                T_POP: begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        alu_opcode_d = pop_opcode;
                        alu_op1_d    = pop_acc;
                        alu_op2_d    = acc_q;
                        depth_d      = depth_dec;
                        state_d      = S_CALC;
                    end
                end
                T_CLEAR: begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    depth_d = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Control and datapath registers; reset also aborts an in-flight CALC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            carry_q      <= 1'b0;
            depth_q      <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            alu_opcode_q <= '0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            carry_q      <= carry_d;
            depth_q      <= depth_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            alu_opcode_q <= alu_opcode_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
        end
    end

    // Stack entries are plain storage; depth_q alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= {cmd.cmd_opcode, acc_q};
        end
    end

    assign alu_opcode    = alu_opcode_q;
    assign alu_op1       = alu_op1_q;
    assign alu_op2       = alu_op2_q;
    assign acc_out       = acc_q;
    assign carry_out     = carry_q;
    assign depth         = depth_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule
